// File: rtl/alu_if.sv
// Operand/result bundle for the ALU. The master drives the operands and selects;
// the slave returns combinational and registered results.
interface alu_if;
    localparam int unsigned XLEN   = 32;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned F3_W   = 3;

    logic [XLEN-1:0] in1;
    logic [XLEN-1:0] in2;
    logic [OP_W-1:0] alu_op;
    logic [F3_W-1:0] funct3;
    logic [XLEN-1:0] result;
    logic            cond;
    logic [XLEN-1:0] result_q;
    logic            cond_q;

    modport master (
        output in1, in2, alu_op, funct3,
        input  result, cond, result_q, cond_q
    );

    modport slave (
        input  in1, in2, alu_op, funct3,
        output result, cond, result_q, cond_q
    );
endinterface

// File: rtl/alu.sv
// RV32 integer ALU: combinational result/branch compare plus a one-cycle registered copy.
// Define ALU_MULDIV_EN to build the M-extension (alu_op 12); otherwise that op yields 0.
module alu (
    input  logic clk,
    input  logic rst_n,
    alu_if.slave bus
);
    localparam int unsigned XLEN  = 32;
    localparam int unsigned SHW   = 5;

    localparam logic [3:0] OP_ADD    = 4'd0;
    localparam logic [3:0] OP_SUB    = 4'd1;
    localparam logic [3:0] OP_SLL    = 4'd2;
    localparam logic [3:0] OP_SLT    = 4'd3;
    localparam logic [3:0] OP_SLTU   = 4'd4;
    localparam logic [3:0] OP_XOR    = 4'd5;
    localparam logic [3:0] OP_SRL    = 4'd6;
    localparam logic [3:0] OP_SRA    = 4'd7;
    localparam logic [3:0] OP_OR     = 4'd8;
    localparam logic [3:0] OP_AND    = 4'd9;
    localparam logic [3:0] OP_PASSB  = 4'd10;
    localparam logic [3:0] OP_MULDIV = 4'd12;

    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [SHW-1:0]  shamt;
    logic            eq;
    logic            lt_s;
    logic            lt_u;
    logic [XLEN-1:0] result_c;
    logic            cond_c;
    logic [XLEN-1:0] muldiv_c;

    assign a     = bus.in1;
    assign b     = bus.in2;
    assign shamt = b[SHW-1:0];
    assign eq    = (a == b);
    assign lt_s  = ($signed(a) < $signed(b));
    assign lt_u  = (a < b);

`ifdef ALU_MULDIV_EN
    localparam int unsigned PW = 2 * XLEN;
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    logic [PW-1:0]   a_ext;
    logic [PW-1:0]   b_ext;
    logic [PW-1:0]   prod;
    logic            div_zero;
    logic            div_ovf;
    logic [XLEN-1:0] quot_s;
    logic [XLEN-1:0] quot_u;
    logic [XLEN-1:0] rem_s;
    logic [XLEN-1:0] rem_u;

    // One unsigned multiplier; extension choice makes the low 64 bits match the signed product.
    assign a_ext = (bus.funct3 == 3'b001 || bus.funct3 == 3'b010)
                 ? {{XLEN{a[XLEN-1]}}, a} : {{XLEN{1'b0}}, a};
    assign b_ext = (bus.funct3 == 3'b001)
                 ? {{XLEN{b[XLEN-1]}}, b} : {{XLEN{1'b0}}, b};
    assign prod  = a_ext * b_ext;

    assign div_zero = (b == '0);
    assign div_ovf  = (a == INT_MIN) && (b == '1);
    assign quot_s   = XLEN'($signed(a) / $signed(b));
    assign rem_s    = XLEN'($signed(a) % $signed(b));
    assign quot_u   = a / b;
    assign rem_u    = a % b;

    // Divide-by-zero and INT_MIN/-1 are resolved here, never by the divider itself.
    always_comb begin
        muldiv_c = '0;
        case (bus.funct3)
            3'b000:                 muldiv_c = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: muldiv_c = prod[PW-1:XLEN];
            3'b100:  muldiv_c = div_zero ? '1 : (div_ovf ? INT_MIN : quot_s);
            3'b101:  muldiv_c = div_zero ? '1 : quot_u;
            3'b110:  muldiv_c = div_zero ? a  : (div_ovf ? '0 : rem_s);
            3'b111:  muldiv_c = div_zero ? a  : rem_u;
            default: muldiv_c = '0;
        endcase
    end
`else
    assign muldiv_c = '0;
`endif

    always_comb begin
        result_c = '0;
        case (bus.alu_op)
            OP_ADD:    result_c = a + b;
            OP_SUB:    result_c = a - b;
            OP_SLL:    result_c = a << shamt;
            OP_SLT:    result_c = XLEN'(lt_s);
            OP_SLTU:   result_c = XLEN'(lt_u);
            OP_XOR:    result_c = a ^ b;
            OP_SRL:    result_c = a >> shamt;
            OP_SRA:    result_c = XLEN'($signed(a) >>> shamt);
            OP_OR:     result_c = a | b;
            OP_AND:    result_c = a & b;
            OP_PASSB:  result_c = b;
            OP_MULDIV: result_c = muldiv_c;
            default:   result_c = '0;
        endcase
    end

    // Branch compare is evaluated regardless of alu_op.
    always_comb begin
        cond_c = 1'b0;
        case (bus.funct3)
            3'b000:  cond_c = eq;
            3'b001:  cond_c = ~eq;
            3'b100:  cond_c = lt_s;
            3'b101:  cond_c = ~lt_s;
            3'b110:  cond_c = lt_u;
            3'b111:  cond_c = ~lt_u;
            default: cond_c = 1'b0;
        endcase
    end

    assign bus.result = result_c;
    assign bus.cond   = cond_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.result_q <= '0;
            bus.cond_q   <= 1'b0;
        end else begin
            bus.result_q <= result_c;
            bus.cond_q   <= cond_c;
        end
    end
endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for alu: combinational ops, branch compare,
// optional M-extension (ALU_MULDIV_EN) and the registered/reset path.
module tb_alu;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    typedef struct packed {
        logic [3:0]  op;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    alu_if bus ();

    alu dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [3:0] op, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b);
        bus.alu_op = op;
        bus.funct3 = f3;
        bus.in1    = a;
        bus.in2    = b;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(4'd0, 3'b000, 32'd0, 32'd0);
        #3;
        checks++;
        if (bus.result_q !== 32'd0) begin
            failures++;
            $display("FAIL reset_result_q got=%h exp=%h", bus.result_q, 32'd0);
        end
        checks++;
        if (bus.cond_q !== 1'b0) begin
            failures++;
            $display("FAIL reset_cond_q got=%b exp=0", bus.cond_q);
        end
        drive(4'd0, 3'b000, 32'd10, 32'd20);
        #1;
        checks++;
        if (bus.result !== 32'd30) begin
            failures++;
            $display("FAIL reset_comb_result got=%h exp=%h", bus.result, 32'd30);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.result_q !== 32'd0) begin
            failures++;
            $display("FAIL reset_held_across_edge got=%h exp=%h", bus.result_q, 32'd0);
        end
    endtask

    task automatic test_ops();
        vec_t v [0:19];
        v = '{
            '{4'd0,  3'b000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000},
            '{4'd1,  3'b000, 32'h00000000, 32'h00000001, 32'hFFFFFFFF},
            '{4'd1,  3'b000, 32'h00000005, 32'h00000007, 32'hFFFFFFFE},
            '{4'd2,  3'b000, 32'h00000001, 32'h00000021, 32'h00000002},
            '{4'd2,  3'b000, 32'h0000000F, 32'h00000004, 32'h000000F0},
            '{4'd7,  3'b000, 32'h80000000, 32'h00000024, 32'hF8000000},
            '{4'd6,  3'b000, 32'h80000000, 32'h00000024, 32'h08000000},
            '{4'd7,  3'b000, 32'h7FFFFFF0, 32'h00000004, 32'h07FFFFFF},
            '{4'd3,  3'b000, 32'hFFFFFFFF, 32'h00000001, 32'h00000001},
            '{4'd4,  3'b000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000},
            '{4'd3,  3'b000, 32'h00000001, 32'hFFFFFFFF, 32'h00000000},
            '{4'd4,  3'b000, 32'h00000001, 32'hFFFFFFFF, 32'h00000001},
            '{4'd5,  3'b000, 32'hFF00FF00, 32'h0F0F0F0F, 32'hF00FF00F},
            '{4'd8,  3'b000, 32'hFF00FF00, 32'h0F0F0F0F, 32'hFF0FFF0F},
            '{4'd9,  3'b000, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00},
            '{4'd10, 3'b000, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0F0F0F0F},
            '{4'd11, 3'b000, 32'hFF00FF00, 32'h0F0F0F0F, 32'h00000000},
            '{4'd13, 3'b000, 32'h12345678, 32'h00000001, 32'h00000000},
            '{4'd15, 3'b000, 32'h12345678, 32'h00000001, 32'h00000000},
            '{4'd6,  3'b000, 32'hF0000000, 32'h00000000, 32'hF0000000}
        };
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive(v[i].op, v[i].f3, v[i].a, v[i].b);
            #1;
            checks++;
            if (bus.result !== v[i].exp) begin
                failures++;
                $display("FAIL op_vec%0d op=%0d got=%h exp=%h", i, v[i].op, bus.result, v[i].exp);
            end
        end
    endtask

    task automatic test_cond();
        logic [31:0] a_v [0:1];
        logic [31:0] b_v [0:1];
        logic [7:0]  exp_v [0:1];
        // Bit k is the expected cond for funct3 = k.
        a_v[0] = 32'hFFFFFFFF; b_v[0] = 32'h00000001; exp_v[0] = 8'b1001_0010;
        a_v[1] = 32'h00000005; b_v[1] = 32'h00000005; exp_v[1] = 8'b1010_0001;
        for (int s = 0; s < 2; s++) begin
            for (int f = 0; f < 8; f++) begin
                @(negedge clk);
                drive(4'd11, 3'(f), a_v[s], b_v[s]);
                #1;
                checks++;
                if (bus.cond !== exp_v[s][f]) begin
                    failures++;
                    $display("FAIL cond_set%0d_f3_%0d got=%b exp=%b", s, f, bus.cond, exp_v[s][f]);
                end
            end
        end
    endtask

    task automatic test_muldiv();
        vec_t v [0:11];
`ifdef ALU_MULDIV_EN
        v = '{
            '{4'd12, 3'b100, 32'h00000007, 32'h00000000, 32'hFFFFFFFF},
            '{4'd12, 3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF},
            '{4'd12, 3'b001, 32'h80000000, 32'h80000000, 32'h40000000},
            '{4'd12, 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000},
            '{4'd12, 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000},
            '{4'd12, 3'b101, 32'h00000007, 32'h00000000, 32'hFFFFFFFF},
            '{4'd12, 3'b111, 32'h00000007, 32'h00000000, 32'h00000007},
            '{4'd12, 3'b110, 32'h00000009, 32'h00000000, 32'h00000009},
            '{4'd12, 3'b000, 32'h00000003, 32'h00000005, 32'h0000000F},
            '{4'd12, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE},
            '{4'd12, 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF},
            '{4'd12, 3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD}
        };
`else
        v = '{
            '{4'd12, 3'b000, 32'h00000003, 32'h00000005, 32'h00000000},
            '{4'd12, 3'b001, 32'h80000000, 32'h80000000, 32'h00000000},
            '{4'd12, 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000},
            '{4'd12, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000},
            '{4'd12, 3'b100, 32'h00000007, 32'h00000000, 32'h00000000},
            '{4'd12, 3'b101, 32'h00000007, 32'h00000000, 32'h00000000},
            '{4'd12, 3'b110, 32'hFFFFFFF9, 32'h00000002, 32'h00000000},
            '{4'd12, 3'b111, 32'h00000007, 32'h00000003, 32'h00000000},
            '{4'd12, 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h00000000},
            '{4'd12, 3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000},
            '{4'd12, 3'b001, 32'h12345678, 32'h9ABCDEF0, 32'h00000000},
            '{4'd12, 3'b110, 32'h00000009, 32'h00000000, 32'h00000000}
        };
`endif
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(v[i].op, v[i].f3, v[i].a, v[i].b);
            #1;
            checks++;
            if (bus.result !== v[i].exp) begin
                failures++;
                $display("FAIL muldiv_vec%0d f3=%0d got=%h exp=%h", i, v[i].f3, bus.result, v[i].exp);
            end
        end
        // cond must still follow funct3 on the MULDIV op (LTU: 0xFFFFFFF9 < 2 is false).
        @(negedge clk);
        drive(4'd12, 3'b110, 32'hFFFFFFF9, 32'h00000002);
        #1;
        checks++;
        if (bus.cond !== 1'b0) begin
            failures++;
            $display("FAIL muldiv_cond got=%b exp=0", bus.cond);
        end
    endtask

    task automatic test_registered();
        @(negedge clk);
        rst_n = 1'b1;
        drive(4'd0, 3'b001, 32'd2, 32'd3);
        #1;
        checks++;
        if (bus.result_q !== 32'd0) begin
            failures++;
            $display("FAIL reg_before_edge got=%h exp=%h", bus.result_q, 32'd0);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.result_q !== 32'd5) begin
            failures++;
            $display("FAIL reg_result_q got=%h exp=%h", bus.result_q, 32'd5);
        end
        checks++;
        if (bus.cond_q !== 1'b1) begin
            failures++;
            $display("FAIL reg_cond_q got=%b exp=1", bus.cond_q);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.result_q !== 32'd0) begin
            failures++;
            $display("FAIL midreset_result_q got=%h exp=%h", bus.result_q, 32'd0);
        end
        checks++;
        if (bus.cond_q !== 1'b0) begin
            failures++;
            $display("FAIL midreset_cond_q got=%b exp=0", bus.cond_q);
        end
        checks++;
        if (bus.result !== 32'd5) begin
            failures++;
            $display("FAIL midreset_comb_result got=%h exp=%h", bus.result, 32'd5);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.result_q !== 32'd0) begin
            failures++;
            $display("FAIL release_before_edge got=%h exp=%h", bus.result_q, 32'd0);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.result_q !== 32'd5) begin
            failures++;
            $display("FAIL release_first_edge got=%h exp=%h", bus.result_q, 32'd5);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a_v [0:3];
        logic [31:0] exp_q;
        a_v[0] = 32'h00000011; a_v[1] = 32'h00000022;
        a_v[2] = 32'hFFFFFFF0; a_v[3] = 32'h00000100;
        exp_q = 32'd5;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(4'd0, 3'b000, a_v[i], 32'h00000001);
            #1;
            checks++;
            if (bus.result_q !== exp_q) begin
                failures++;
                $display("FAIL b2b_hold%0d got=%h exp=%h", i, bus.result_q, exp_q);
            end
            exp_q = a_v[i] + 32'h00000001;
            @(posedge clk); #1;
            checks++;
            if (bus.result_q !== exp_q) begin
                failures++;
                $display("FAIL b2b_capture%0d got=%h exp=%h", i, bus.result_q, exp_q);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_ops();
        test_cond();
        test_muldiv();
        test_registered();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 The block SHALL have the following ports, clock and reset first:
- clk, input, 1 bit: single clock; the only clock of the block.
- rst_n, input, 1 bit: asynchronous, active-low reset.
- in1, input, 32 bits: operand A, rs1 value or PC.
- in2, input, 32 bits: operand B, rs2 value, immediate or constant 4.
- alu_op, input, 4 bits: operation select, encoding per REQ-004.
- funct3, input, 3 bits: selects the compare condition and the M-extension sub-operation.
- result, output, 32 bits: combinational ALU result.
- cond, output, 1 bit: combinational branch-compare result.
- result_q, output, 32 bits: result registered on clk.
- cond_q, output, 1 bit: cond registered on clk.

Function
REQ-002 result and cond SHALL be purely combinational functions of in1, in2, alu_op and funct3, with zero-cycle latency.
REQ-003 All arithmetic SHALL be 32-bit modulo 2^32; carries and overflow SHALL be discarded and no flags exported.
REQ-004 The alu_op encoding and resulting operation SHALL be:
- 0 ADD: in1+in2.
- 1 SUB: in1-in2.
- 2 SLL: in1 << in2[4:0].
- 3 SLT: signed in1<in2 gives 1, else 0.
- 4 SLTU: unsigned in1<in2 gives 1, else 0.
- 5 XOR.
- 6 SRL: logical shift right by in2[4:0].
- 7 SRA: arithmetic shift right by in2[4:0].
- 8 OR.
- 9 AND.
- 10 PASSB: result = in2.
- 11 CMP: result = 0.
- 12 MULDIV: per REQ-007.
- 13..15: result = 0.
REQ-005 Only in2[4:0] SHALL affect shifts; in2[31:5] SHALL be ignored.
REQ-006 cond SHALL be evaluated for every alu_op, using in1 vs in2:
- funct3 000 (EQ): equal.
- funct3 001 (NE): not equal.
- funct3 100 (LT): signed less than.
- funct3 101 (GE): signed greater or equal.
- funct3 110 (LTU): unsigned less than.
- funct3 111 (GEU): unsigned greater or equal.
- funct3 010 and 011: cond = 0.
REQ-007 With alu_op = 12 and the macro of REQ-013 defined, funct3 SHALL select:
- 000 MUL: low 32 bits of the product.
- 001 MULH: high 32 bits, signed x signed.
- 010 MULHSU: high 32 bits, signed in1 x unsigned in2.
- 011 MULHU: high 32 bits, unsigned x unsigned.
- 100 DIV: signed quotient, truncated toward zero.
- 101 DIVU: unsigned quotient.
- 110 REM: signed remainder; its sign SHALL follow the dividend.
- 111 REMU: unsigned remainder.
REQ-008 Division by zero SHALL give:
- DIV and DIVU: 0xFFFFFFFF.
- REM and REMU: in1.
REQ-009 Signed overflow (in1 = 0x80000000 with in2 = 0xFFFFFFFF) SHALL give:
- DIV: 0x80000000.
- REM: 0.
REQ-010 On every rising edge of clk, result_q SHALL take the current value of result and cond_q the current value of cond; the registered outputs SHALL have exactly one cycle of latency.

Reset
REQ-011 While rst_n = 0, result_q and cond_q SHALL be forced to 0 immediately, without waiting for clk.
REQ-012 Reset SHALL have no effect on result and cond. Updates of result_q and cond_q SHALL resume at the first rising edge of clk after rst_n rises. A reset asserted mid-operation SHALL discard the pending registered value.

Configuration
REQ-013 The macro ALU_MULDIV_EN SHALL control the M-extension:
- Defined: alu_op = 12 implements REQ-007 to REQ-009.
- Not defined: no multiplier or divider logic is built, and alu_op = 12 gives result = 0.
- cond is unaffected in both cases.

Verification
REQ-014 ADD 0xFFFFFFFF + 0x00000001 -> result 0x00000000; SUB 0x00000000 - 0x00000001 -> result 0xFFFFFFFF.
REQ-015 SRA in1 = 0x80000000, in2 = 0x00000024 -> result 0xF8000000 (shift amount 4); SRL with the same operands -> result 0x08000000.
REQ-016 in1 = 0xFFFFFFFF, in2 = 0x00000001:
- funct3 100 (LT) -> cond 1; funct3 110 (LTU) -> cond 0.
- SLT -> result 1; SLTU -> result 0.
REQ-017 With ALU_MULDIV_EN defined:
- DIV 7 / 0 -> result 0xFFFFFFFF.
- REM in1 = -7, in2 = 2 -> result 0xFFFFFFFF.
- MULH 0x80000000 x 0x80000000 -> result 0x40000000.
- DIV 0x80000000 / 0xFFFFFFFF -> result 0x80000000.
Without the macro, alu_op = 12 -> result 0.
REQ-018 Registered path:
- Apply ADD 2 + 3 -> result_q = 5 after one clk edge.
- Assert rst_n = 0 between edges -> result_q = 0 and cond_q = 0 immediately, while result stays 5.
